conv2d_ofm_writeback: RTL and testbench

//  Downstream write-back stage of the 2D convolution accelerator. Consumes the OFM result stream

---
 rtl/conv2d_pkg.sv | 22 ++
 rtl/conv2d_ofm_writeback_if.sv | 32 +++
 rtl/conv2d_wb_slot.sv | 32 +++
 rtl/conv2d_ofm_writeback.sv | 118 +++++++++++
 tb/tb_conv2d_ofm_writeback.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2d_pkg.sv
// Shared write-back definitions: FSM state encodings, default address stride, fm_dim width.
// Pure declarations; no timing or flow-control behaviour of its own.
// total = fm_dim^2 is computed from the low FM_DIM_BITS of fm_dim only.
package conv2d_pkg;

    localparam int FM_DIM_BITS    = 16;
    localparam int WB_ADDR_STRIDE = 4;

    typedef enum logic [1:0] {
        WB_IDLE  = 2'd0,
        WB_RUN   = 2'd1,
        WB_DRAIN = 2'd2,
        WB_DONE  = 2'd3
    } wb_state_t;

    function automatic logic [31:0] ofm_total(input logic [31:0] fm_dim);
        logic [FM_DIM_BITS-1:0] side;
        side = fm_dim[FM_DIM_BITS-1:0];
        return 32'(side) * 32'(side);
    endfunction

endpackage

// File: rtl/conv2d_ofm_writeback_if.sv
// Control, OFM stream and memory write port of the write-back stage.
// slave = the write-back stage itself, master = controller/engine/memory side.
// Flow control is valid/ready on both the OFM stream and the memory port.
interface conv2d_ofm_writeback_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              wb_start;
    logic [AWIDTH-1:0] ofm_base_addr;
    logic [31:0]       fm_dim;
    logic [DWIDTH-1:0] ofm_dout;
    logic              ofm_dout_valid;
    logic              ofm_dout_ready;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic              mem_din_valid;
    logic              mem_din_ready;
    logic              mem_we;
    logic              wb_idle;
    logic              wb_done;

    modport slave (
        input  wb_start, ofm_base_addr, fm_dim, ofm_dout, ofm_dout_valid, mem_din_ready,
        output ofm_dout_ready, mem_addr, mem_din, mem_din_valid, mem_we, wb_idle, wb_done
    );

    modport master (
        output wb_start, ofm_base_addr, fm_dim, ofm_dout, ofm_dout_valid, mem_din_ready,
        input  ofm_dout_ready, mem_addr, mem_din, mem_din_valid, mem_we, wb_idle, wb_done
    );

endinterface

// File: rtl/conv2d_wb_slot.sv
// Single-entry registered valid/ready slice carrying {addr,data} to the memory port.
// Latency 1 cycle; full throughput while out_rdy stays high.
// Backpressure: out_dat held while out_vld & ~out_rdy; in_rdy = ~out_vld | out_rdy.
module conv2d_wb_slot #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_dat,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_dat
);

    assign in_rdy = ~out_vld | out_rdy;

    // A load while the held entry drains refills the slot with valid left high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld <= 1'b0;
            out_dat <= '0;
        end else if (in_vld && in_rdy) begin
            out_vld <= 1'b1;
            out_dat <= in_dat;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/conv2d_ofm_writeback.sv
// OFM write-back: addresses each result word from a base and issues write requests; OFM_RELU_EN adds ReLU.
// Latency 1 cycle input fire -> mem_din_valid; 1 word/cycle while mem_din_ready is high.
// Backpressure: ofm_dout_ready drops when the slot is stalled or total words were accepted.
module conv2d_ofm_writeback
    import conv2d_pkg::*;
#(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int ADDR_STRIDE = WB_ADDR_STRIDE
) (
    input  logic                   clk,
    input  logic                   rst,
    conv2d_ofm_writeback_if.slave  wb
);

    wb_state_t         state;
    wb_state_t         state_nxt;
    logic [31:0]       total;
    logic [31:0]       accepted;
    logic [AWIDTH-1:0] next_addr;
    logic              done_r;
    logic              st_idle;
    logic              st_run;
    logic              st_done;
    logic              start_acc;
    logic              in_fire;
    logic              mem_fire;
    logic              slot_in_rdy;
    logic [31:0]       total_new;
    logic [DWIDTH-1:0] wr_dat;

    assign total_new = ofm_total(wb.fm_dim);
    assign start_acc = wb.wb_start && st_idle;
    assign in_fire   = wb.ofm_dout_valid && wb.ofm_dout_ready;
    assign mem_fire  = wb.mem_din_valid && wb.mem_din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE:  if (wb.wb_start) state_nxt = (total_new == 32'd0) ? WB_DONE : WB_RUN;
            WB_RUN:   if (in_fire && (accepted == total - 32'd1)) state_nxt = WB_DRAIN;
            WB_DRAIN: if (mem_fire) state_nxt = WB_DONE;
            WB_DONE:  state_nxt = WB_IDLE;
            default:  state_nxt = WB_IDLE;
        endcase
    end

    always_comb begin
        st_idle = 1'b0;
        st_run  = 1'b0;
        st_done = 1'b0;
        case (state)
            WB_IDLE: st_idle = 1'b1;
            WB_RUN:  st_run  = 1'b1;
            WB_DONE: st_done = 1'b1;
            default: ;
        endcase
    end

    // Address generator and word counter; address arithmetic wraps modulo 2^AWIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total     <= '0;
            accepted  <= '0;
            next_addr <= '0;
        end else if (start_acc) begin
            total     <= total_new;
            accepted  <= '0;
            next_addr <= wb.ofm_base_addr;
        end else if (in_fire) begin
            accepted  <= accepted + 32'd1;
            next_addr <= next_addr + AWIDTH'(ADDR_STRIDE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_r <= 1'b0;
        end else if (start_acc) begin
            done_r <= 1'b0;
        end else if (st_done) begin
            done_r <= 1'b1;
        end
    end

`ifdef OFM_RELU_EN
    assign wr_dat = wb.ofm_dout[DWIDTH-1] ? '0 : wb.ofm_dout;
`else
    assign wr_dat = wb.ofm_dout;
`endif

    assign wb.ofm_dout_ready = st_run && (accepted < total) && slot_in_rdy;
    assign wb.mem_we         = wb.mem_din_valid;
    assign wb.wb_idle        = st_idle;
    assign wb.wb_done        = done_r;

    conv2d_wb_slot #(
        .WIDTH (AWIDTH + DWIDTH)
    ) u_slot (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_fire),
        .in_rdy  (slot_in_rdy),
        .in_dat  ({next_addr, wr_dat}),
        .out_vld (wb.mem_din_valid),
        .out_rdy (wb.mem_din_ready),
        .out_dat ({wb.mem_addr, wb.mem_din})
    );

endmodule

// File: tb/tb_conv2d_ofm_writeback.sv
// Scoreboard bench for conv2d_ofm_writeback: accepted input words queue expected {addr,data},
// memory-side fires pop and compare; pass control, stalls, wrap and reset are checked inline.
module tb_conv2d_ofm_writeback;

    logic clk;
    logic rst;

    conv2d_ofm_writeback_if #(.AWIDTH(32), .DWIDTH(32)) wb_if ();

    conv2d_ofm_writeback #(
        .AWIDTH      (32),
        .DWIDTH      (32),
        .ADDR_STRIDE (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb_if)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    logic [63:0] sb_q[$];
    logic [31:0] pass_base;
    int          k_in;
    int          wr_cnt;
    int          first_in_cyc;
    int          first_out_cyc;
    int          last_out_cyc;
    bit          rmode;
    bit          prev_stall;
    logic [63:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] relu_model(input logic [31:0] d);
`ifdef OFM_RELU_EN
        return d[31] ? 32'd0 : d;
`else
        return d;
`endif
    endfunction

    // Memory ready driver: steady high or random per cycle.
    initial begin
        wb_if.mem_din_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            wb_if.mem_din_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: push on input fire, pop on memory fire, check hold under stall.
    initial begin
        logic [63:0] exp;
        logic [31:0] eaddr;
        prev_stall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check_eq("stall_hold", {wb_if.mem_addr, wb_if.mem_din}, held);
                if (wb_if.ofm_dout_valid && wb_if.ofm_dout_ready) begin
                    eaddr = pass_base + 32'(k_in) * 32'd4;
                    sb_q.push_back({eaddr, relu_model(wb_if.ofm_dout)});
                    if (k_in == 0) first_in_cyc = cyc;
                    k_in++;
                end
                if (wb_if.mem_din_valid && wb_if.mem_din_ready) begin
                    if (wr_cnt == 0) first_out_cyc = cyc;
                    last_out_cyc = cyc;
                    wr_cnt++;
                    check_eq("mem_we", {63'd0, wb_if.mem_we}, 64'd1);
                    if (sb_q.size() == 0) begin
                        check_eq("sb_underflow", 64'd0, 64'd1);
                    end else begin
                        exp = sb_q.pop_front();
                        check_eq("addr", {32'd0, wb_if.mem_addr}, {32'd0, exp[63:32]});
                        check_eq("data", {32'd0, wb_if.mem_din}, {32'd0, exp[31:0]});
                    end
                end
                prev_stall = wb_if.mem_din_valid && !wb_if.mem_din_ready;
                held = {wb_if.mem_addr, wb_if.mem_din};
            end
        end
    end

    task automatic start_pass(input logic [31:0] base, input logic [31:0] dim);
        pass_base = base;
        k_in = 0;
        wr_cnt = 0;
        sb_q.delete();
        wb_if.ofm_base_addr = base;
        wb_if.fm_dim = dim;
        wb_if.wb_start = 1'b1;
        @(posedge clk);
        #1;
        wb_if.wb_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input int budget, output bit acc);
        acc = 1'b0;
        wb_if.ofm_dout = d;
        wb_if.ofm_dout_valid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (wb_if.ofm_dout_ready) begin
                acc = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
        end
        if (!acc) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (wb_if.wb_done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, {63'd0, seen}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        logic [31:0] words[4];
        rmode = 1'b0;
        pass_base = '0;
        k_in = 0;
        wr_cnt = 0;
        rst = 1'b1;
        wb_if.wb_start = 1'b0;
        wb_if.ofm_base_addr = '0;
        wb_if.fm_dim = '0;
        wb_if.ofm_dout = '0;
        wb_if.ofm_dout_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_valid", {63'd0, wb_if.mem_din_valid}, 64'd0);
        check_eq("rst_we",    {63'd0, wb_if.mem_we}, 64'd0);
        check_eq("rst_addr",  {32'd0, wb_if.mem_addr}, 64'd0);
        check_eq("rst_din",   {32'd0, wb_if.mem_din}, 64'd0);
        check_eq("rst_done",  {63'd0, wb_if.wb_done}, 64'd0);
        check_eq("rst_idle",  {63'd0, wb_if.wb_idle}, 64'd1);
        check_eq("rst_rdy",   {63'd0, wb_if.ofm_dout_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 3x3 back-to-back, memory always ready
        start_pass(32'h100, 32'd3);
        check_eq("t1_busy", {63'd0, wb_if.wb_idle}, 64'd0);
        for (int d = 1; d <= 9; d++) begin
            send_word(32'(d), 50, acc);
            check_eq("t1_acc", {63'd0, acc}, 64'd1);
        end
        wb_if.ofm_dout_valid = 1'b0;
        wait_done("t1_done");
        check_eq("t1_writes", 64'(wr_cnt), 64'd9);
        check_eq("t1_latency", 64'(first_out_cyc - first_in_cyc), 64'd1);
        check_eq("t1_thruput", 64'(last_out_cyc - first_out_cyc), 64'd8);
        check_eq("t1_sb_empty", 64'(sb_q.size()), 64'd0);

        // 2x2 with random memory stalls; a 5th word must never be taken
        rmode = 1'b1;
        start_pass(32'h400, 32'd2);
        check_eq("t2_done_clr", {63'd0, wb_if.wb_done}, 64'd0);
        for (int d = 0; d < 4; d++) begin
            send_word(32'hA0 + 32'(d), 200, acc);
            check_eq("t2_acc", {63'd0, acc}, 64'd1);
        end
        send_word(32'hDEAD, 30, acc);
        check_eq("t2_no_5th", {63'd0, acc}, 64'd0);
        wb_if.ofm_dout_valid = 1'b0;
        wait_done("t2_done");
        rmode = 1'b0;
        check_eq("t2_writes", 64'(wr_cnt), 64'd4);
        check_eq("t2_in_cnt", 64'(k_in), 64'd4);
        check_eq("t2_sb_empty", 64'(sb_q.size()), 64'd0);

        // zero-size pass: DONE then IDLE, no write
        start_pass(32'h300, 32'd0);
        @(negedge clk);
        check_eq("t3_in_done", {63'd0, wb_if.wb_idle}, 64'd0);
        check_eq("t3_done_lo", {63'd0, wb_if.wb_done}, 64'd0);
        @(negedge clk);
        check_eq("t3_idle", {63'd0, wb_if.wb_idle}, 64'd1);
        check_eq("t3_done", {63'd0, wb_if.wb_done}, 64'd1);
        check_eq("t3_no_valid", {63'd0, wb_if.mem_din_valid}, 64'd0);
        check_eq("t3_writes", 64'(wr_cnt), 64'd0);
        @(posedge clk);
        #1;

        // address wrap, plus a wb_start during RUN that must be ignored
        start_pass(32'hFFFF_FFFC, 32'd2);
        send_word(32'h11, 50, acc);
        check_eq("t4_acc", {63'd0, acc}, 64'd1);
        wb_if.wb_start = 1'b1;
        wb_if.ofm_base_addr = 32'h555;
        send_word(32'h22, 50, acc);
        wb_if.wb_start = 1'b0;
        check_eq("t4_acc", {63'd0, acc}, 64'd1);
        send_word(32'h33, 50, acc);
        send_word(32'h44, 50, acc);
        wb_if.ofm_dout_valid = 1'b0;
        wait_done("t4_done");
        check_eq("t4_writes", 64'(wr_cnt), 64'd4);

        // ReLU behaviour (or bit-exact pass-through when disabled)
        words[0] = 32'hFFFF_FFF6;
        words[1] = 32'h7;
        words[2] = 32'h8000_0000;
        words[3] = 32'h7FFF_FFFF;
        start_pass(32'h40, 32'd2);
        for (int i = 0; i < 4; i++) begin
            send_word(words[i], 50, acc);
            check_eq("t5_acc", {63'd0, acc}, 64'd1);
        end
        wb_if.ofm_dout_valid = 1'b0;
        wait_done("t5_done");
        check_eq("t5_writes", 64'(wr_cnt), 64'd4);

        // reset mid-pass after 3 of 9 writes, then restart from base
        start_pass(32'h200, 32'd3);
        for (int d = 0; d < 3; d++) begin
            send_word(32'h50 + 32'(d), 50, acc);
            check_eq("t6_acc", {63'd0, acc}, 64'd1);
        end
        wb_if.ofm_dout_valid = 1'b0;
        for (int i = 0; i < 50 && wr_cnt < 3; i++) @(negedge clk);
        check_eq("t6_pre_writes", 64'(wr_cnt), 64'd3);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", {63'd0, wb_if.mem_din_valid}, 64'd0);
        check_eq("t6_rst_addr", {32'd0, wb_if.mem_addr}, 64'd0);
        check_eq("t6_rst_idle", {63'd0, wb_if.wb_idle}, 64'd1);
        check_eq("t6_rst_rdy", {63'd0, wb_if.ofm_dout_ready}, 64'd0);
        check_eq("t6_rst_done", {63'd0, wb_if.wb_done}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_pass(32'h200, 32'd2);
        for (int d = 0; d < 4; d++) begin
            send_word(32'h60 + 32'(d), 50, acc);
            check_eq("t6_acc2", {63'd0, acc}, 64'd1);
        end
        wb_if.ofm_dout_valid = 1'b0;
        wait_done("t6_done");
        check_eq("t6_writes", 64'(wr_cnt), 64'd4);
        check_eq("t6_sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
